reg_file: RTL
=============

# reg_file

Architectural register file with rename tags, sitting directly downstream of the reorder buffer's commit port and beside the decoder's operand lookup. It holds the 32 committed integer registers plus, per register, a busy flag and the ROB index of the youngest in-flight producer. The decoder reads sources and allocates destinations; the ROB retires values into it; a ROB roll-back discards all rename state.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers (x0 hard-wired zero)
- ROB_IDX_BITS, 4, width of a ROB index (ROB_SIZE 16)

Ports:
- clk  input  1  system clock; single clock domain
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  ready; when low all state holds, outputs stay combinational on held state
- roll_back  input  1  from ROB; mispredict flush
- de_rd_en  input  1  decoder allocates a destination this cycle
- de_rd  input  5  destination register index
- de_rob_idx  input  ROB_IDX_BITS  ROB entry producing de_rd
- de_rs1, de_rs2  input  5  source register indices to look up
- rs1_busy_out, rs2_busy_out  output  1  source still awaits a producer
- rs1_dep_out, rs2_dep_out  output  ROB_IDX_BITS  producer ROB index (valid when busy)
- rs1_val_out, rs2_val_out  output  32  register value (valid when not busy)
- rf_in_en  input  1  ROB commits a register write
- rf_rob_idx_in  input  ROB_IDX_BITS  ROB index of committing entry
- rf_dest_in  input  5  committed destination
- rf_val_in  input  32  committed value

## Operation
- State: val[0..31] (32b), busy[0..31], tag[0..31] (ROB_IDX_BITS).
- Lookup (combinational, per source s): if s==0 -> busy 0, dep 0, val 0. Else if rf_in_en && rf_dest_in==s && busy[s] && tag[s]==rf_rob_idx_in -> busy 0, val rf_val_in (commit bypass). Else if rf_in_en && rf_dest_in==s && !busy[s] -> busy 0, val rf_val_in. Else busy=busy[s], dep=tag[s], val=val[s].
- Lookup never sees the same-cycle de_rd_en allocation (instruction reading its own destination gets the old mapping).
- Commit (clock edge, rdy_in high, rf_in_en, rf_dest_in!=0): val[rf_dest_in] <= rf_val_in unconditionally. busy cleared only if tag[rf_dest_in]==rf_rob_idx_in and no same-cycle allocation to that register.
- Allocate (clock edge, rdy_in high, !roll_back, de_rd_en, de_rd!=0): busy[de_rd] <= 1, tag[de_rd] <= de_rob_idx. Allocation wins over commit clear on the same register.
- Roll-back (rdy_in high, roll_back): all busy <= 0; tags unchanged; allocation ignored; commit value write still performed.
- Writes or allocations to x0 ignored; val[0] stays 0, busy[0] stays 0.

## Timing
- Reset (rst_in high at edge): all val, busy, tag <= 0; rst_in overrides rdy_in and roll_back. After reset all lookups return busy 0, dep 0, val 0.
- Lookup: zero-cycle combinational from de_rs*, rf_* and state.
- Commit/allocate/flush: visible in state one edge after assertion.
- rdy_in low: no state update regardless of other inputs.
- Tag reuse: ROB index may wrap (15 -> 0); only exact tag match clears busy, so stale commits from an overwritten mapping leave busy set.
- Simultaneous commit + allocate, same register: val updated, busy 1, tag = de_rob_idx.
- Simultaneous commit + allocate, different registers: both applied.

## Test plan
- Reset, then read x5/x31 -> busy 0, val 0; commit x0 val 0xDEADBEEF -> x0 reads 0.
- Allocate x3 tag 2; next cycle read x3 -> busy 1, dep 2; commit x3 tag 2 val 0x1234 -> same-cycle read busy 0 val 0x1234, next cycle busy 0 val 0x1234.
- Allocate x4 tag 1, then x4 tag 5; commit x4 tag 1 val 7 -> val 7 stored, busy stays 1, dep 5; commit tag 5 val 9 -> busy 0 val 9.
- Same cycle: commit x6 tag 3 val 0xAA, allocate x6 tag 8, read x6 -> read gives busy 0 val 0xAA; next cycle busy 1 dep 8 val 0xAA.
- Allocate x1..x10 tags 0..9, assert roll_back with commit x2 val 0x55 and allocate x11 tag 10 -> next cycle all busy 0, x2 val 0x55, x11 not busy.
- rdy_in low with commit x7 val 1 and allocate x8 -> no change; rdy_in high then applies.

Source files
------------

// File: rtl/reg_file_if.sv
// Decoder / ROB-commit bundle for the architectural register file.
// The decoder and ROB side drive through the master modport. The register
// file is the slave: it answers the operand lookups and absorbs commits.
interface reg_file_if #(
  parameter int ROB_IDX_BITS = 4
);
  // Destination allocation from the decoder
  logic                    de_rd_en;
  logic [4:0]              de_rd;
  logic [ROB_IDX_BITS-1:0] de_rob_idx;

  // Source operand lookup
  logic [4:0]              de_rs1;
  logic [4:0]              de_rs2;
  logic                    rs1_busy_out;
  logic                    rs2_busy_out;
  logic [ROB_IDX_BITS-1:0] rs1_dep_out;
  logic [ROB_IDX_BITS-1:0] rs2_dep_out;
  logic [31:0]             rs1_val_out;
  logic [31:0]             rs2_val_out;

  // Commit port from the reorder buffer
  logic                    rf_in_en;
  logic [ROB_IDX_BITS-1:0] rf_rob_idx_in;
  logic [4:0]              rf_dest_in;
  logic [31:0]             rf_val_in;

  modport master (
    output de_rd_en, de_rd, de_rob_idx, de_rs1, de_rs2,
    output rf_in_en, rf_rob_idx_in, rf_dest_in, rf_val_in,
    input  rs1_busy_out, rs2_busy_out, rs1_dep_out, rs2_dep_out,
    input  rs1_val_out, rs2_val_out
  );

  modport slave (
    input  de_rd_en, de_rd, de_rob_idx, de_rs1, de_rs2,
    input  rf_in_en, rf_rob_idx_in, rf_dest_in, rf_val_in,
    output rs1_busy_out, rs2_busy_out, rs1_dep_out, rs2_dep_out,
    output rs1_val_out, rs2_val_out
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with rename tags.
// Each register has a committed value, a busy flag and the ROB index of its
// youngest in-flight producer. A commit only frees a register when it comes
// from that youngest producer. A commit from an older, overwritten mapping
// still writes the value but leaves the register busy.
module reg_file #(
  parameter int REG_NUM      = 32,
  parameter int ROB_IDX_BITS = 4
) (
  input logic        clk,
  input logic        rst_in,
  input logic        rdy_in,
  input logic        roll_back,
  reg_file_if.slave  bus
);

  typedef struct packed {
    logic                    busy;
    logic [ROB_IDX_BITS-1:0] dep;
    logic [31:0]             val;
  } lookup_t;

  logic [31:0]             val_r  [REG_NUM];
  logic                    busy_r [REG_NUM];
  logic [ROB_IDX_BITS-1:0] tag_r  [REG_NUM];

  logic [REG_NUM-1:0] commit_hit_s;
  logic [REG_NUM-1:0] alloc_hit_s;
  logic [REG_NUM-1:0] clear_hit_s;
  lookup_t            rs1_s;
  lookup_t            rs2_s;

  // A same-cycle commit is forwarded to the lookup when it would free the
  // register, or when the register has no producer outstanding. The lookup
  // ignores any allocation made in the same cycle.
  function automatic lookup_t lookup(
    input logic [4:0]              src,
    input logic                    cm_en,
    input logic [4:0]              cm_dest,
    input logic [ROB_IDX_BITS-1:0] cm_idx,
    input logic [31:0]             cm_val
  );
    lookup_t r;
    r.busy = 1'b0;
    r.dep  = '0;
    r.val  = 32'h0;
    if (src == 5'd0) begin
      r.busy = 1'b0;
    end else if (cm_en && (cm_dest == src) &&
                 (!busy_r[src] || (tag_r[src] == cm_idx))) begin
      r.busy = 1'b0;
      r.dep  = tag_r[src];
      r.val  = cm_val;
    end else begin
      r.busy = busy_r[src];
      r.dep  = tag_r[src];
      r.val  = val_r[src];
    end
    return r;
  endfunction

  // Decode, for each register, whether a commit, an allocation or a busy
  // clear targets it this cycle. Entry 0 never matches.
  always_comb begin
    commit_hit_s = '0;
    alloc_hit_s  = '0;
    clear_hit_s  = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      commit_hit_s[i] = bus.rf_in_en && (bus.rf_dest_in == 5'(i));
      alloc_hit_s[i]  = bus.de_rd_en && !roll_back && (bus.de_rd == 5'(i));
      clear_hit_s[i]  = commit_hit_s[i] && (tag_r[i] == bus.rf_rob_idx_in);
    end
  end

  // State update. Reset overrides everything. When not ready, all state
  // holds. Allocation wins over a commit clear, and roll-back frees every
  // register.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_r[i]  <= 32'h0;
        busy_r[i] <= 1'b0;
        tag_r[i]  <= '0;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (commit_hit_s[i]) begin
          val_r[i] <= bus.rf_val_in;
        end
        if (roll_back) begin
          busy_r[i] <= 1'b0;
        end else if (alloc_hit_s[i]) begin
          busy_r[i] <= 1'b1;
          tag_r[i]  <= bus.de_rob_idx;
        end else if (clear_hit_s[i]) begin
          busy_r[i] <= 1'b0;
        end
      end
    end
  end

  // Combinational operand lookup for both decoder sources.
  always_comb begin
    rs1_s = lookup(bus.de_rs1, bus.rf_in_en, bus.rf_dest_in,
                   bus.rf_rob_idx_in, bus.rf_val_in);
    rs2_s = lookup(bus.de_rs2, bus.rf_in_en, bus.rf_dest_in,
                   bus.rf_rob_idx_in, bus.rf_val_in);
    bus.rs1_busy_out = rs1_s.busy;
    bus.rs1_dep_out  = rs1_s.dep;
    bus.rs1_val_out  = rs1_s.val;
    bus.rs2_busy_out = rs2_s.busy;
    bus.rs2_dep_out  = rs2_s.dep;
    bus.rs2_val_out  = rs2_s.val;
  end

endmodule
